mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, address width.
REQ-002 SHALL have parameters: DATA_W, default 16, data width.
REQ-003 SHALL have parameters: MEM_LAT, default 2, memory read latency in cycles (legal 1..15).
REQ-004 SHALL have parameters: STARVE_MAX, default 3, maximum consecutive LS grants while IF waits (legal 1..7).
REQ-005 SHALL have ports, clock and reset first (one clock; reset synchronous, active-high):
 CLK  in  1  clock, rising edge
 RST  in  1  synchronous active-high reset
 if_req  in  1  fetch request, held until if_gnt
 if_addr  in  ADDR_W  fetch address
 if_gnt  out  1  one-cycle grant to fetch
 if_rvalid  out  1  one-cycle fetch data valid
 ls_req  in  1  load/store request, held until ls_gnt
 ls_we  in  1  1=store, 0=load
 ls_addr  in  ADDR_W  load/store address
 ls_wdata  in  DATA_W  store data
 ls_gnt  out  1  one-cycle grant to load/store
 ls_rvalid  out  1  one-cycle load data valid / store done
 rdata  out  DATA_W  shared return data
 mem_en  out  1  memory access strobe
 mem_we  out  1  memory write enable
 mem_addr  out  ADDR_W  memory address
 mem_wdata  out  DATA_W  memory write data
 mem_rdata  in  DATA_W  memory read data
 stall  out  1  pipeline stall request

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-007 In IDLE, with any request present: SHALL pulse the winner's gnt, latch addr/we/wdata and owner, and go to ACCESS next cycle.
REQ-008 In IDLE with no request: SHALL remain in IDLE with all pulses low.
REQ-009 ACCESS SHALL last exactly one cycle, with mem_en=1 and mem_we/mem_addr/mem_wdata driven from the latched values.
REQ-010 After ACCESS, the block SHALL spend MEM_LAT-1 cycles in WAIT (zero WAIT cycles when MEM_LAT=1), then one cycle in RESP.
REQ-011 In RESP: SHALL register mem_rdata (loads/fetches) or 0 (stores) into rdata, pulse only the owner's rvalid, and return to IDLE.
REQ-012 Grant to rvalid latency SHALL be MEM_LAT+1 cycles; the next grant occurs at the earliest in the cycle after RESP (throughput: one access per MEM_LAT+2 cycles).
REQ-013 Priority SHALL be LS over IF.
REQ-014 Exception to priority: when both requests are present and starve_cnt==STARVE_MAX, IF SHALL win.
REQ-015 starve_cnt (3 bits) SHALL increment on each LS grant while if_req=1, saturating at STARVE_MAX.
REQ-016 starve_cnt SHALL clear on every IF grant.
REQ-017 rdata SHALL hold its last value outside RESP.
REQ-018 mem_en SHALL be 0 outside ACCESS.
REQ-019 mem_we SHALL be 0 whenever mem_en is 0.
REQ-020 Requests SHALL be sampled only in IDLE; a request dropped before its grant SHALL be ignored.
REQ-021 An access once granted SHALL complete even if the requester drops its request.
REQ-022 stall SHALL be 1 whenever (if_req or ls_req) is 1 and the respective rvalid is not pulsing in that cycle, and whenever the FSM is not IDLE.
REQ-023 Simultaneous new requests in RESP SHALL wait for IDLE; no grant is issued in RESP.

Reset
REQ-024 RST=1 at a CLK edge SHALL force IDLE, starve_cnt=0, rdata=0, and all outputs 0 (gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, stall).
REQ-025 RST asserted mid-operation SHALL abort the access with no rvalid pulse; the first grant after reset is possible in the first cycle RST=0.

Structure
REQ-026 The state encoding (IDLE=0, ACCESS=1, WAIT=2, RESP=3) and owner encoding (OWN_IF=0, OWN_LS=1) SHALL live in the shared processor definitions package alongside the opcode constants.
REQ-027 The latency counter SHALL be a sub-module lat_counter (load MEM_LAT-1, decrement, zero flag).
REQ-028 No other sub-modules SHALL be used.

Verification
REQ-029 Lone fetch, MEM_LAT=2: if_req, if_addr=0x0010, mem_rdata=0xBEEF -> if_gnt at T, mem_en at T+1, if_rvalid with rdata=0xBEEF at T+3.
REQ-030 Contention: both requests in the same cycle, ls_we=0 -> ls_gnt first; if_gnt 4 cycles later; stall=1 throughout.
REQ-031 Starvation, STARVE_MAX=3: if_req held, ls_req held -> grant order LS, LS, LS, IF, LS.
REQ-032 Store: ls_we=1, ls_addr=0x0020, ls_wdata=0x1234 -> mem_en=mem_we=1 with addr 0x0020 and data 0x1234 for one cycle; ls_rvalid with rdata=0.
REQ-033 Reset in WAIT -> next cycle IDLE, no rvalid, all outputs 0; a pending if_req is granted the first cycle after RST=0.
REQ-034 MEM_LAT=1 with a dropped request: if_req pulsed, then dropped after grant -> access completes and if_rvalid arrives 2 cycles after grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared processor definitions: arbiter FSM/owner encodings and core opcode constants.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Memory latency down-counter: loaded at grant, decremented through ACCESS/WAIT.
module lat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, LS priority
// with starvation guard for fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  arb_state_t        state, state_nxt;
  owner_t            owner;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] resp_data;
  logic [2:0]        starve_cnt;
  logic              starved, ls_win, if_win, grant, lat_zero, lat_dec;

  // Fetch overrides LS priority only once it has been passed over STARVE_MAX times.
  always_comb begin
    starved = if_req && ls_req && (starve_cnt == 3'(STARVE_MAX));
    ls_win  = ls_req && !starved;
    if_win  = if_req && !ls_win;
    grant   = !RST && (state == IDLE) && (if_req || ls_req);
    lat_dec = (state == ACCESS) || (state == WAIT);
    resp_data = lat_we ? '0 : mem_rdata;
  end

  lat_counter #(
    .WIDTH (LAT_CNT_W)
  ) u_lat_counter (
    .clk      (CLK),
    .rst      (RST),
    .load     (grant),
    .load_val (LAT_CNT_W'(MEM_LAT - 1)),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:         if (if_req || ls_req) state_nxt = ACCESS;
      ACCESS, WAIT: state_nxt = lat_zero ? RESP : WAIT;
      RESP:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = rdata_q;
    if (!RST) begin
      unique case (state)
        IDLE: begin
          if_gnt = if_win;
          ls_gnt = ls_win;
        end
        ACCESS: begin
          mem_en    = 1'b1;
          mem_we    = lat_we;
          mem_addr  = lat_addr;
          mem_wdata = lat_wdata;
        end
        RESP: begin
          if_rvalid = (owner == OWN_IF);
          ls_rvalid = (owner == OWN_LS);
          rdata     = resp_data;
        end
        default: ;
      endcase
    end
    stall = !RST && ((if_req && !if_rvalid) || (ls_req && !ls_rvalid) || (state != IDLE));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner      <= OWN_IF;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant) begin
        owner     <= ls_win ? OWN_LS : OWN_IF;
        lat_addr  <= ls_win ? ls_addr : if_addr;
        lat_we    <= ls_win && ls_we;
        lat_wdata <= ls_win ? ls_wdata : '0;
        if (if_win) begin
          starve_cnt <= '0;
        end else if (if_req && (starve_cnt != 3'(STARVE_MAX))) begin
          starve_cnt <= starve_cnt + 3'd1;
        end
      end
      if (state == RESP) begin
        rdata_q <= resp_data;
      end
    end
  end

endmodule
